// File: rtl/imem_port_arbiter.sv
// Arbitrates the instruction-memory port between fetch (read-only) and loader (read/write).
// Optional build macro: IMEM_ARB_MISALIGN_CHECK_EN rejects fetches whose address is not word aligned.
module imem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    f_req_i,
    input  logic [ADDR_WIDTH-1:0]   f_addr_i,
    output logic                    f_gnt_o,
    output logic                    f_rvalid_o,
    output logic [DATA_WIDTH-1:0]   f_rdata_o,
    output logic                    f_err_o,
    input  logic                    l_req_i,
    input  logic                    l_we_i,
    input  logic [DATA_WIDTH/8-1:0] l_be_i,
    input  logic [ADDR_WIDTH-1:0]   l_addr_i,
    input  logic [DATA_WIDTH-1:0]   l_wdata_i,
    input  logic                    l_lock_i,
    output logic                    l_gnt_o,
    output logic                    l_rvalid_o,
    output logic [DATA_WIDTH-1:0]   l_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    dbg_lock_o
);
    localparam int N_BYTES = DATA_WIDTH / 8;
    localparam int CW      = $clog2(MAX_WAIT + 1);

    // Handshake: a requester holds req and payload stable until gnt; gnt is combinational and
    // the transfer happens in the gnt cycle. The response (rvalid, rdata) follows one cycle later.
    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           wait_q, wait_d;
    logic                    starved;
    logic                    f_win, l_win;
    logic                    f_misalign;
    logic                    f_rvalid_q, l_rvalid_q, err_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    assign starved = (wait_q == CW'(MAX_WAIT));

`ifdef IMEM_ARB_MISALIGN_CHECK_EN
    assign f_misalign = (f_addr_i[1:0] != 2'b00);
`else
    assign f_misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        f_win   = 1'b0;
        l_win   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ARB: begin
                    if (l_req_i && (!f_req_i || starved)) begin
                        l_win = 1'b1;
                        if (l_lock_i) state_d = LOCK;
                    end else if (f_req_i) begin
                        f_win = 1'b1;
                    end
                end
                LOCK: begin
                    // Fetch is shut out; an idle loader cycle or an unlocked grant releases the port.
                    l_win = l_req_i;
                    if (!l_req_i || !l_lock_i) state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        wait_d = '0;
        if (l_req_i && !l_win) wait_d = starved ? wait_q : wait_q + CW'(1);
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rdata_d     = mem_rdata_i;
        if (l_win) begin
            mem_req_o   = 1'b1;
            mem_we_o    = l_we_i;
            mem_be_o    = l_we_i ? l_be_i : {N_BYTES{1'b1}};
            mem_addr_o  = l_addr_i;
            mem_wdata_o = l_wdata_i;
            if (l_we_i) rdata_d = '0;
        end else if (f_win) begin
            if (f_misalign) begin
                rdata_d = '0;
            end else begin
                mem_req_o  = 1'b1;
                mem_be_o   = {N_BYTES{1'b1}};
                mem_addr_o = f_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            wait_q     <= '0;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            f_rvalid_q <= f_win;
            l_rvalid_q <= l_win;
            err_q      <= f_win && f_misalign;
            if (f_win || l_win) rdata_q <= rdata_d;
        end
    end

    assign f_gnt_o    = f_win;
    assign l_gnt_o    = l_win;
    assign f_rvalid_o = f_rvalid_q;
    assign l_rvalid_o = l_rvalid_q;
    assign f_rdata_o  = rdata_q;
    assign l_rdata_o  = rdata_q;
    assign f_err_o    = err_q;
    assign dbg_lock_o = (state_q == LOCK);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vectors plus a cycle-by-cycle rule model.
module tb_imem_port_arbiter;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [3:0]  l_be;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        dbg_lock;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
        .f_rdata_o(f_rdata), .f_err_o(f_err),
        .l_req_i(l_req), .l_we_i(l_we), .l_be_i(l_be), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_lock_i(l_lock), .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .dbg_lock_o(dbg_lock)
    );

    // Memory array behind the port: combinational read, byte-enabled write on the clock edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_req && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit misaligned(input logic [31:0] a);
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Rule model: who may use the port this cycle, and what each requester sees one cycle later.
    bit          m_lock = 0;
    int          m_wait = 0;
    bit          m_fv = 0, m_lv = 0, m_err = 0;
    logic [31:0] m_rdata = '0;

    always @(negedge clk) begin
        bit ef, el, ereq;
        ef = 0; el = 0;
        if (!rst) begin
            if (m_lock)                                       el = l_req;
            else if (l_req && (!f_req || m_wait >= MAX_WAIT)) el = 1;
            else                                              ef = f_req;
        end
        ereq = el || (ef && !misaligned(f_addr));
        chk("f_gnt", f_gnt, ef);
        chk("l_gnt", l_gnt, el);
        chk("mem_req", mem_req, ereq);
        chk("mem_we", mem_we, el && l_we);
        chk("mem_be", mem_be, !ereq ? 4'h0 : (el && l_we) ? l_be : 4'hF);
        chk("mem_addr", mem_addr, !ereq ? 32'h0 : el ? l_addr : f_addr);
        if (el && l_we) chk("mem_wdata", mem_wdata, l_wdata);
        if (!ereq)      chk("mem_wdata_idle", mem_wdata, 32'h0);
        chk("f_rvalid", f_rvalid, m_fv);
        chk("l_rvalid", l_rvalid, m_lv);
        chk("f_rdata", f_rdata, m_rdata);
        chk("l_rdata", l_rdata, m_rdata);
        chk("f_err", f_err, m_err);
        chk("dbg_lock", dbg_lock, m_lock);
        if (rst) begin
            m_lock = 0; m_wait = 0; m_fv = 0; m_lv = 0; m_err = 0; m_rdata = '0;
        end else begin
            m_fv  = ef;
            m_lv  = el;
            m_err = ef && misaligned(f_addr);
            if (el)      m_rdata = l_we ? 32'h0 : mem[l_addr[9:2]];
            else if (ef) m_rdata = misaligned(f_addr) ? 32'h0 : mem[f_addr[9:2]];
            if (m_lock)  m_lock = l_req && l_lock;
            else         m_lock = el && l_lock;
            if (l_req && !el) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else              m_wait = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ldr(input bit req, input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit lock);
        l_req = req; l_we = we; l_be = be; l_addr = addr; l_wdata = wdata; l_lock = lock;
    endtask

    bit gf [0:9];
    bit gl [0:9];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1]  = 32'hDEADBEEF;
        mem[64] = 32'h5555AAAA;
        rst = 1'b1;
        f_req = 1'b1; f_addr = 32'h4;
        ldr(1, 0, 4'h0, 32'h100, 32'h0, 0);

        // Reset with both requesters active
        repeat (2) begin
            @(negedge clk);
            chk("rst_f_gnt", f_gnt, 0);
            chk("rst_l_gnt", l_gnt, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_rvalid", {f_rvalid, l_rvalid, f_err}, 0);
            chk("rst_rdata", f_rdata, 32'h0);
            next_cycle();
        end
        rst = 1'b0;

        // Contention: fetch 8 times, forced loader on the 9th, then fetch again
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gf[i] = f_gnt;
            gl[i] = l_gnt;
            if (i == 1) begin
                chk("fetch_rvalid", f_rvalid, 1);
                chk("fetch_rdata", f_rdata, 32'hDEADBEEF);
            end
            if (i == 9) begin
                chk("forced_l_rvalid", l_rvalid, 1);
                chk("forced_l_rdata", l_rdata, 32'h5555AAAA);
                chk("forced_f_rvalid", f_rvalid, 0);
            end
            next_cycle();
        end
        for (int i = 0; i < 10; i++) begin
            chk("starve_f_gnt", gf[i], i != 8);
            chk("starve_l_gnt", gl[i], i == 8);
        end
        f_req = 1'b0; l_req = 1'b0;
        @(negedge clk);
        chk("resume_f_rvalid", f_rvalid, 1);
        chk("resume_f_rdata", f_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        chk("pulse_f_rvalid", f_rvalid, 0);
        chk("hold_f_rdata", f_rdata, 32'hDEADBEEF);
        next_cycle();

        // Locked write burst while fetch keeps requesting
        ldr(1, 1, 4'b0011, 32'h100, 32'hA5A51234, 1);
        @(negedge clk); chk("lock0_l_gnt", l_gnt, 1); next_cycle();
        f_req = 1'b1;
        ldr(1, 1, 4'hF, 32'h104, 32'h01020304, 1);
        @(negedge clk);
        chk("lock1_f_gnt", f_gnt, 0);
        chk("lock1_l_gnt", l_gnt, 1);
        chk("wr_ack", l_rvalid, 1);
        chk("wr_ack_rdata", l_rdata, 32'h0);
        next_cycle();
        ldr(1, 1, 4'hF, 32'h108, 32'h05060708, 1);
        @(negedge clk); chk("lock2_f_gnt", f_gnt, 0); next_cycle();
        ldr(1, 1, 4'hF, 32'h10C, 32'h090A0B0C, 0);
        @(negedge clk);
        chk("lock3_f_gnt", f_gnt, 0);
        chk("lock3_l_gnt", l_gnt, 1);
        next_cycle();
        l_req = 1'b0;
        @(negedge clk); chk("unlock_f_gnt", f_gnt, 1); next_cycle();

        // Read back the partially written word
        f_req = 1'b0;
        ldr(1, 0, 4'h0, 32'h100, 32'h0, 0);
        @(negedge clk); chk("rd_l_gnt", l_gnt, 1); next_cycle();
        l_req = 1'b0;
        @(negedge clk);
        chk("rd_l_rvalid", l_rvalid, 1);
        chk("rd_l_rdata", l_rdata, 32'h55551234);
        chk("rd_f_rvalid", f_rvalid, 0);
        next_cycle();
        chk("mem_104", mem[65], 32'h01020304);

        // Lock released by an idle loader cycle; fetch waits one cycle
        ldr(1, 1, 4'hF, 32'h110, 32'hCAFEF00D, 1);
        @(negedge clk); chk("idle_lock_l_gnt", l_gnt, 1); next_cycle();
        l_req = 1'b0; f_req = 1'b1;
        @(negedge clk); chk("idle_lock_f_gnt", f_gnt, 0); next_cycle();
        @(negedge clk); chk("idle_release_f_gnt", f_gnt, 1); next_cycle();

        // Reset while locked with a write pending
        f_req = 1'b0;
        ldr(1, 1, 4'hF, 32'h114, 32'h12345678, 1);
        @(negedge clk); chk("pre_rst_l_gnt", l_gnt, 1); next_cycle();
        rst = 1'b1; f_req = 1'b1;
        ldr(1, 1, 4'hF, 32'h118, 32'h87654321, 1);
        @(negedge clk);
        chk("midrst_gnt", {f_gnt, l_gnt}, 0);
        chk("midrst_mem_req", mem_req, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_f_gnt", f_gnt, 1);
        chk("postrst_l_rvalid", l_rvalid, 0);
        next_cycle();
        chk("no_rst_write", mem[70], 32'h0);
        l_req = 1'b0;

        // Misaligned fetch
        f_addr = 32'h6;
        @(negedge clk);
        chk("mis_f_gnt", f_gnt, 1);
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
        chk("mis_mem_req", mem_req, 0);
`else
        chk("mis_mem_req", mem_req, 1);
        chk("mis_mem_addr", mem_addr, 32'h6);
`endif
        next_cycle();
        f_req = 1'b0;
        @(negedge clk);
        chk("mis_f_rvalid", f_rvalid, 1);
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
        chk("mis_f_err", f_err, 1);
        chk("mis_f_rdata", f_rdata, 32'h0);
`else
        chk("mis_f_err", f_err, 0);
        chk("mis_f_rdata", f_rdata, 32'hDEADBEEF);
`endif
        next_cycle();

        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
